// File: rtl/decoded_branch_resolver.sv
// Decode-stage early branch-misprediction detector: flags the oldest mispredicted lane, squashes
// younger lanes and reports the redirect PC and repaired history, held stable across a group.
module decoded_branch_resolver #(
  parameter int unsigned DECODE_WIDTH = 2,
  parameter int unsigned PC_WIDTH     = 32,
  parameter int unsigned GHIST_WIDTH  = 10
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic                                                stall,
  input  logic                                                decodeComplete,
  input  logic [DECODE_WIDTH-1:0]                             insnValidIn,
  input  logic [32*DECODE_WIDTH-1:0]                          isf,
  input  logic [(1+PC_WIDTH+GHIST_WIDTH)*DECODE_WIDTH-1:0]    brPredIn,
  input  logic [PC_WIDTH*DECODE_WIDTH-1:0]                    pc,
  input  logic [3*DECODE_WIDTH-1:0]                           insnInfo,
  output logic [DECODE_WIDTH-1:0]                             insnValidOut,
  output logic [DECODE_WIDTH-1:0]                             insnFlushed,
  output logic [DECODE_WIDTH-1:0]                             insnFlushTriggering,
  output logic                                                flushTriggered,
  output logic [(1+PC_WIDTH+GHIST_WIDTH)*DECODE_WIDTH-1:0]    brPredOut,
  output logic [PC_WIDTH-1:0]                                 recoveredPC,
  output logic [GHIST_WIDTH-1:0]                              recoveredBrHistory
);

  localparam int unsigned DW    = DECODE_WIDTH;
  localparam int unsigned PW    = PC_WIDTH;
  localparam int unsigned GW    = GHIST_WIDTH;
  localparam int unsigned BW    = 1 + PW + GW;
  localparam int unsigned ResW  = 3 * DW + BW * DW + PW + GW;

  logic [DW-1:0]    valid_out, flushed, trig;
  logic [BW*DW-1:0] bp_out;
  logic [PW-1:0]    rpc;
  logic [GW-1:0]    rhist;
  logic             found;

  logic [31:0]      lane_word;
  logic [PW-1:0]    lane_pc, lane_addr, lane_tgt, out_addr, j_imm, b_imm;
  logic [GW-1:0]    lane_ghist;
  logic             lane_taken, is_cond, is_jal, is_jalr, mis, out_taken;
  logic [7*DW-1:0]  opcode_bits;

  always_comb begin
    valid_out   = '0;
    flushed     = '0;
    trig        = '0;
    bp_out      = '0;
    rpc         = '0;
    rhist       = '0;
    found       = 1'b0;
    lane_word   = '0;
    lane_pc     = '0;
    lane_addr   = '0;
    lane_tgt    = '0;
    out_addr    = '0;
    j_imm       = '0;
    b_imm       = '0;
    lane_ghist  = '0;
    lane_taken  = 1'b0;
    is_cond     = 1'b0;
    is_jal      = 1'b0;
    is_jalr     = 1'b0;
    mis         = 1'b0;
    out_taken   = 1'b0;
    opcode_bits = '0;
    for (int i = 0; i < DW; i++) begin
      lane_word  = isf[i*32 +: 32];
      lane_pc    = pc[i*PW +: PW];
      lane_taken = brPredIn[i*BW + PW + GW];
      lane_addr  = brPredIn[i*BW + GW +: PW];
      lane_ghist = brPredIn[i*BW +: GW];
      is_cond    = insnInfo[i*3 + 2];
      is_jal     = insnInfo[i*3 + 1];
      is_jalr    = insnInfo[i*3];
      opcode_bits[i*7 +: 7] = lane_word[6:0];
      j_imm = {{(PW-21){lane_word[31]}}, lane_word[31], lane_word[19:12], lane_word[20],
               lane_word[30:21], 1'b0};
      b_imm = {{(PW-13){lane_word[31]}}, lane_word[31], lane_word[7], lane_word[30:25],
               lane_word[11:8], 1'b0};
      mis       = 1'b0;
      lane_tgt  = lane_pc + PW'(4);
      out_taken = lane_taken;
      out_addr  = lane_addr;
      if (is_jal) begin
        lane_tgt  = lane_pc + j_imm;
        mis       = !lane_taken || (lane_addr != lane_tgt);
        out_taken = 1'b1;
        out_addr  = lane_tgt;
      end else if (is_cond) begin
        lane_tgt = lane_pc + b_imm;
        mis      = lane_taken && (lane_addr != lane_tgt);
        out_addr = lane_tgt;
      end else if (!is_jalr) begin
        // Non-control instruction predicted taken: fall through to the next sequential PC.
        mis       = lane_taken;
        out_taken = 1'b0;
        out_addr  = lane_pc + PW'(4);
      end
      if (insnValidIn[i]) begin
        bp_out[i*BW +: BW] = brPredIn[i*BW +: BW];
        if (found) begin
          flushed[i] = 1'b1;
        end else begin
          valid_out[i] = 1'b1;
          if (mis) begin
            found              = 1'b1;
            trig[i]            = 1'b1;
            bp_out[i*BW +: BW] = {out_taken, out_addr, lane_ghist};
            rpc                = lane_tgt;
            rhist              = is_cond ? {lane_ghist[GW-2:0], 1'b1} : lane_ghist;
          end
        end
      end
    end
  end

  logic unused_opcode;
  assign unused_opcode = ^opcode_bits;

  logic            first_cycle_q, first_cycle_d;
  logic [ResW-1:0] res_q, res_d, res_c, res;

  assign res_c = {valid_out, flushed, trig, bp_out, rpc, rhist};

  always_comb begin
    first_cycle_d = first_cycle_q;
    res_d         = res_q;
    if (!stall) begin
      first_cycle_d = decodeComplete;
      if (first_cycle_q) res_d = res_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      first_cycle_q <= 1'b1;
      res_q         <= '0;
    end else begin
      first_cycle_q <= first_cycle_d;
      res_q         <= res_d;
    end
  end

  // Later cycles of a multi-cycle group replay the result captured on its first cycle.
  assign res = first_cycle_q ? res_c : res_q;
  assign {insnValidOut, insnFlushed, insnFlushTriggering, brPredOut, recoveredPC,
          recoveredBrHistory} = res;
  assign flushTriggered = |insnFlushTriggering;

endmodule

// File: tb/tb_decoded_branch_resolver.sv
// Self-checking bench for decoded_branch_resolver: directed scenarios then random groups,
// compared against a lane-by-lane reference model with group-hold tracking.
module tb_decoded_branch_resolver;

  localparam int BW = 43;

  logic        clk = 1'b0;
  logic        rst, stall, decodeComplete;
  logic [1:0]  insnValidIn;
  logic [63:0] isf;
  logic [85:0] brPredIn;
  logic [63:0] pc;
  logic [5:0]  insnInfo;
  logic [1:0]  insnValidOut, insnFlushed, insnFlushTriggering;
  logic        flushTriggered;
  logic [85:0] brPredOut;
  logic [31:0] recoveredPC;
  logic [9:0]  recoveredBrHistory;

  decoded_branch_resolver dut (
    .clk                 (clk),
    .rst                 (rst),
    .stall               (stall),
    .decodeComplete      (decodeComplete),
    .insnValidIn         (insnValidIn),
    .isf                 (isf),
    .brPredIn            (brPredIn),
    .pc                  (pc),
    .insnInfo            (insnInfo),
    .insnValidOut        (insnValidOut),
    .insnFlushed         (insnFlushed),
    .insnFlushTriggering (insnFlushTriggering),
    .flushTriggered      (flushTriggered),
    .brPredOut           (brPredOut),
    .recoveredPC         (recoveredPC),
    .recoveredBrHistory  (recoveredBrHistory)
  );

  always #5 clk = ~clk;

  // Lane stimulus; cls: 0 non-control, 1 conditional branch, 2 JAL, 3 JALR.
  logic        m_valid[2];
  logic [31:0] m_word[2], m_pc[2], m_addr[2];
  logic        m_taken[2];
  logic [9:0]  m_gh[2];
  int          m_cls[2];

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      insnValidIn[i]        = m_valid[i];
      isf[i*32 +: 32]       = m_word[i];
      pc[i*32 +: 32]        = m_pc[i];
      brPredIn[i*BW +: BW]  = {m_taken[i], m_addr[i], m_gh[i]};
      insnInfo[i*3 +: 3]    = (m_cls[i] == 1) ? 3'b100 : (m_cls[i] == 2) ? 3'b010 :
                              (m_cls[i] == 3) ? 3'b001 : 3'b000;
    end
  end

  typedef struct packed {
    logic [1:0]  vout, fl, tr;
    logic        ft;
    logic [85:0] bp;
    logic [31:0] rpc;
    logic [9:0]  rh;
  } res_t;

  int   total = 0;
  int   bad = 0;
  logic m_first = 1'b1;
  res_t m_hold = '0;
  res_t m_comb;

  function automatic logic [31:0] jimm(input logic [31:0] w);
    return ((w >> 21) & 32'h3FF) * 2 + ((w >> 20) & 32'h1) * 32'h800 +
           ((w >> 12) & 32'hFF) * 32'h1000 - ((w >> 31) & 32'h1) * 32'h100000;
  endfunction

  function automatic logic [31:0] bimm(input logic [31:0] w);
    return ((w >> 8) & 32'hF) * 2 + ((w >> 25) & 32'h3F) * 32 +
           ((w >> 7) & 32'h1) * 32'h800 - ((w >> 31) & 32'h1) * 32'h1000;
  endfunction

  function automatic res_t model_comb();
    res_t        r = '0;
    bit          hit = 0;
    bit          mis, ct;
    logic [31:0] tgt, ca;
    for (int i = 0; i < 2; i++) begin
      if (m_valid[i]) begin
        r.bp[i*BW +: BW] = {m_taken[i], m_addr[i], m_gh[i]};
        if (hit) begin
          r.fl[i] = 1'b1;
        end else begin
          r.vout[i] = 1'b1;
          mis = 0; ct = m_taken[i]; ca = m_addr[i]; tgt = m_pc[i] + 32'd4;
          case (m_cls[i])
            0: begin mis = m_taken[i]; ct = 1'b0; ca = m_pc[i] + 32'd4; end
            1: begin
              tgt = m_pc[i] + bimm(m_word[i]);
              mis = m_taken[i] && (m_addr[i] != tgt); ca = tgt;
            end
            2: begin
              tgt = m_pc[i] + jimm(m_word[i]);
              mis = !m_taken[i] || (m_addr[i] != tgt); ct = 1'b1; ca = tgt;
            end
            default: mis = 0;
          endcase
          if (mis) begin
            hit = 1;
            r.tr[i] = 1'b1;
            r.ft = 1'b1;
            r.bp[i*BW +: BW] = {ct, ca, m_gh[i]};
            r.rpc = tgt;
            r.rh = (m_cls[i] == 1) ? 10'((32'(m_gh[i]) * 2 + 1) % 1024) : m_gh[i];
          end
        end
      end
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Sample at the falling edge and compare every output against the model.
  task automatic sample(input logic r, input logic st, input logic dc);
    res_t e;
    rst = r; stall = st; decodeComplete = dc;
    @(negedge clk);
    m_comb = model_comb();
    e = m_first ? m_comb : m_hold;
    chk("valid_out", 128'(insnValidOut), 128'(e.vout));
    chk("flushed", 128'(insnFlushed), 128'(e.fl));
    chk("triggering", 128'(insnFlushTriggering), 128'(e.tr));
    chk("flush_triggered", 128'(flushTriggered), 128'(e.ft));
    chk("br_pred_out", 128'(brPredOut), 128'(e.bp));
    chk("recovered_pc", 128'(recoveredPC), 128'(e.rpc));
    chk("recovered_hist", 128'(recoveredBrHistory), 128'(e.rh));
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_first = 1'b1; m_hold = '0;
    end else if (!stall) begin
      if (m_first) m_hold = m_comb;
      m_first = decodeComplete;
    end
    #1;
  endtask

  task automatic step(input logic r, input logic st, input logic dc);
    sample(r, st, dc);
    tick();
  endtask

  task automatic set_lane(input int i, input logic v, input int cls, input logic [31:0] w,
                          input logic [31:0] p, input logic t, input logic [31:0] a,
                          input logic [9:0] g);
    m_valid[i] = v; m_cls[i] = cls; m_word[i] = w; m_pc[i] = p;
    m_taken[i] = t; m_addr[i] = a; m_gh[i] = g;
  endtask

  task automatic load_t1();
    set_lane(0, 1, 0, 32'h0010_0093, 32'h100, 1, 32'h180, 10'h011);
    set_lane(1, 1, 0, 32'h0010_0093, 32'h104, 0, 32'h000, 10'h022);
  endtask

  task automatic load_t4();
    set_lane(0, 1, 2, 32'h0200_00EF, 32'h500, 1, 32'h520, 10'h0F0);
    set_lane(1, 1, 0, 32'h0010_0093, 32'h504, 0, 32'h000, 10'h0F1);
  endtask

  initial begin
    logic [31:0] a;
    for (int i = 0; i < 2; i++) set_lane(i, 0, 0, 32'h0, 32'h0, 0, 32'h0, 10'h0);
    rst = 1'b1; stall = 1'b0; decodeComplete = 1'b1;
    @(posedge clk); @(posedge clk); #1;

    step(0, 0, 1);                       // reset state, no valid lanes

    load_t1();                           // non-control predicted taken
    sample(0, 0, 1);
    chk("t1_pc", 128'(recoveredPC), 128'h104);
    chk("t1_vout", 128'(insnValidOut), 128'b01);
    chk("t1_flushed", 128'(insnFlushed), 128'b10);
    chk("t1_taken0", 128'(brPredOut[42]), 128'b0);
    tick();

    set_lane(0, 1, 2, 32'h0200_00EF, 32'h200, 0, 32'h0, 10'h03A);   // JAL not predicted
    set_lane(1, 0, 0, 32'h0, 32'h0, 0, 32'h0, 10'h0);
    sample(0, 0, 1);
    chk("t2_ft", 128'(flushTriggered), 128'b1);
    chk("t2_pc", 128'(recoveredPC), 128'h220);
    chk("t2_hist", 128'(recoveredBrHistory), 128'h03A);
    tick();

    set_lane(0, 1, 0, 32'h0010_0093, 32'h300, 0, 32'h0, 10'h001);   // BEQ wrong target
    set_lane(1, 1, 1, 32'h0000_0463, 32'h304, 1, 32'h400, 10'h155);
    sample(0, 0, 1);
    chk("t3_pc", 128'(recoveredPC), 128'h30C);
    chk("t3_hist", 128'(recoveredBrHistory), 128'h2AB);
    chk("t3_trig", 128'(insnFlushTriggering), 128'b10);
    tick();

    load_t4();                           // everything predicted correctly
    sample(0, 0, 1);
    chk("t4_ft", 128'(flushTriggered), 128'b0);
    chk("t4_vout", 128'(insnValidOut), 128'b11);
    chk("t4_bp", 128'(brPredOut), 128'(brPredIn));
    tick();

    load_t1();                           // multi-cycle group holds its first result
    step(0, 0, 0);
    load_t4();
    sample(0, 0, 0);
    chk("t5_hold_pc", 128'(recoveredPC), 128'h104);
    tick();
    step(0, 0, 1);
    step(0, 0, 1);

    load_t1();                           // reset mid-group, then stall across a boundary
    step(0, 0, 0);
    step(1, 0, 0);
    load_t4();
    step(0, 0, 0);
    load_t1();
    step(0, 1, 1);
    sample(0, 1, 1);
    chk("t6_stall_pc", 128'(recoveredPC), 128'h0);
    tick();
    step(0, 0, 1);
    step(0, 0, 1);

    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 2; i++) begin
        set_lane(i, 1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 3)), $urandom(),
                 $urandom() & 32'hFFFF_FFFC, 1'($urandom()), $urandom(), 10'($urandom()));
        if ($urandom_range(0, 1) == 1) begin
          a = m_pc[i] + 32'd4;
          if (m_cls[i] == 1) a = m_pc[i] + bimm(m_word[i]);
          if (m_cls[i] == 2) a = m_pc[i] + jimm(m_word[i]);
          m_addr[i] = a;
        end
      end
      step(1'($urandom_range(0, 40) == 0), 1'($urandom_range(0, 4) == 0),
           1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
